// File: rtl/udp_test_pkg.sv
// Shared constants, state encodings and arithmetic helpers for the UDP test frame
// generator and checker.
package udp_test_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [7:0]  IP_TTL         = 8'h40;
    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;
    localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REFL  = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB_20E3;
    localparam int          PREAMBLE_LEN   = 8;
    localparam int          HEADER_LEN     = 42;
    localparam int          HEADER_BITS    = 8 * HEADER_LEN;
    localparam int          FCS_LEN        = 4;
    localparam int          IDX_W          = 11;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_PREAMBLE,
        TX_HEADER,
        TX_PAYLOAD,
        TX_FCS
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_PREAMBLE,
        RX_DATA,
        RX_DROP
    } rx_state_t;

    // Reflected CRC-32 advanced by one byte, data LSB first.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    // IPv4 header checksum over the ten header words with the checksum word taken as zero.
    function automatic logic [15:0] ip_checksum(input logic [15:0] total_len, input logic [15:0] id,
                                                input logic [31:0] src_ip, input logic [31:0] dst_ip);
        logic [19:0] sum;
        sum = 20'(16'h4500) + 20'(total_len) + 20'(id) + 20'(16'h4000)
            + 20'({IP_TTL, IP_PROTO_UDP})
            + 20'(src_ip[31:16]) + 20'(src_ip[15:0])
            + 20'(dst_ip[31:16]) + 20'(dst_ip[15:0]);
        sum = 20'(sum[15:0]) + 20'(sum[19:16]);
        sum = 20'(sum[15:0]) + 20'(sum[19:16]);
        return ~sum[15:0];
    endfunction

endpackage

// File: rtl/udp_test_if.sv
// Byte-wide GMII transmit/receive bundle between the UDP test block and the PCS.
interface udp_test_if;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;

    modport master (
        output gmii_txd, gmii_tx_en, gmii_tx_er,
        input  gmii_rxd, gmii_rx_dv, gmii_rx_er
    );

    modport slave (
        input  gmii_txd, gmii_tx_en, gmii_tx_er,
        output gmii_rxd, gmii_rx_dv, gmii_rx_er
    );
endinterface

// File: rtl/crc32_d8.sv
// Byte-per-cycle IEEE 802.3 CRC-32 register; i_init reloads all ones, i_en folds in i_data.
module crc32_d8
    import udp_test_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_init) begin
            r_crc <= CRC_INIT;
        end else if (i_en) begin
            r_crc <= crc32_next(r_crc, i_data);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/udp_test_top.sv
// Periodic Ethernet/IPv4/UDP test frame transmitter with FCS-checking receiver.
// Define UDP_RX_CHECK_EN to compile in the receive checker; otherwise rx_good/rx_bad are 0.
module udp_test_top
    import udp_test_pkg::*;
#(
    parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC     = 48'h00_0A_35_01_02_03,
    parameter logic [31:0] SRC_IP      = 32'hC0A8010A,
    parameter logic [31:0] DST_IP      = 32'hC0A80102,
    parameter logic [15:0] SRC_PORT    = 16'd8080,
    parameter logic [15:0] DST_PORT    = 16'd8080,
    parameter int          PAYLOAD_LEN = 18,
    parameter int          GAP_CYCLES  = 125000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        link_up,
    udp_test_if.master  gmii,
    output logic        led_link,
    output logic        rx_good,
    output logic        rx_bad
);

    localparam int          GAP_W     = $clog2(GAP_CYCLES);
    localparam logic [15:0] TOTAL_LEN = 16'(28 + PAYLOAD_LEN);
    localparam logic [15:0] UDP_LEN   = 16'(8 + PAYLOAD_LEN);

    logic                   r_link_meta, r_link_sync;
    tx_state_t              r_state, w_state_nxt;
    logic [IDX_W-1:0]       r_idx, w_idx_nxt;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic [15:0]            r_seq, r_ip_csum;
    logic [7:0]             r_txd, w_txd;
    logic                   r_tx_en, w_tx_en;
    logic                   w_crc_en, w_tx_crc_init, w_gap_done;
    logic [31:0]            w_tx_crc, w_fcs_sh;
    logic [HEADER_BITS-1:0] w_hdr, w_hdr_sh;

    // NOTE: synchronous reset clears every control flop; nothing here is a memory array.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_link_meta <= 1'b0;
            r_link_sync <= 1'b0;
        end else begin
            r_link_meta <= link_up;
            r_link_sync <= r_link_meta;
        end
    end

    assign led_link   = r_link_sync;
    assign w_gap_done = r_link_sync && (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));

    assign w_hdr = {DST_MAC, SRC_MAC, ETHERTYPE_IPV4, 8'h45, 8'h00, TOTAL_LEN, r_seq,
                    16'h4000, IP_TTL, IP_PROTO_UDP, r_ip_csum, SRC_IP, DST_IP,
                    SRC_PORT, DST_PORT, UDP_LEN, 16'h0000};
    assign w_hdr_sh = w_hdr << {r_idx, 3'b000};
    assign w_fcs_sh = (~w_tx_crc) >> {r_idx[1:0], 3'b000};

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx + IDX_W'(1);
        w_txd       = 8'h00;
        w_tx_en     = 1'b0;
        w_crc_en    = 1'b0;
        unique case (r_state)
            TX_IDLE: begin
                w_idx_nxt = '0;
                if (w_gap_done) w_state_nxt = TX_PREAMBLE;
            end
            TX_PREAMBLE: begin
                w_tx_en = 1'b1;
                w_txd   = (r_idx == IDX_W'(PREAMBLE_LEN - 1)) ? SFD_BYTE : PREAMBLE_BYTE;
                if (r_idx == IDX_W'(PREAMBLE_LEN - 1)) begin
                    w_state_nxt = TX_HEADER;
                    w_idx_nxt   = '0;
                end
            end
            TX_HEADER: begin
                w_tx_en  = 1'b1;
                w_crc_en = 1'b1;
                w_txd    = w_hdr_sh[HEADER_BITS-1 -: 8];
                if (r_idx == IDX_W'(HEADER_LEN - 1)) begin
                    w_state_nxt = TX_PAYLOAD;
                    w_idx_nxt   = '0;
                end
            end
            TX_PAYLOAD: begin
                w_tx_en  = 1'b1;
                w_crc_en = 1'b1;
                w_txd    = r_idx[7:0];
                if (r_idx == IDX_W'(PAYLOAD_LEN - 1)) begin
                    w_state_nxt = TX_FCS;
                    w_idx_nxt   = '0;
                end
            end
            TX_FCS: begin
                w_tx_en = 1'b1;
                w_txd   = w_fcs_sh[7:0];
                if (r_idx == IDX_W'(FCS_LEN - 1)) begin
                    w_state_nxt = TX_IDLE;
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = TX_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= TX_IDLE;
            r_idx     <= '0;
            r_gap_cnt <= '0;
            r_seq     <= '0;
            r_ip_csum <= '0;
            r_txd     <= '0;
            r_tx_en   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_txd   <= w_txd;
            r_tx_en <= w_tx_en;
            if (r_state == TX_IDLE && r_link_sync && !w_gap_done) begin
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end else begin
                r_gap_cnt <= '0;
            end
            // Checksum settles during the gap, so the header mux never sees the adder chain.
            if (r_state == TX_IDLE) begin
                r_ip_csum <= ip_checksum(TOTAL_LEN, r_seq, SRC_IP, DST_IP);
            end
            if (r_state == TX_FCS && w_state_nxt == TX_IDLE) begin
                r_seq <= r_seq + 16'd1;
            end
        end
    end

    assign w_tx_crc_init = (r_state == TX_IDLE) || (r_state == TX_PREAMBLE);

    crc32_d8 u_tx_crc (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .i_init (w_tx_crc_init),
        .i_en   (w_crc_en),
        .i_data (w_txd),
        .o_crc  (w_tx_crc)
    );

    assign gmii.gmii_txd   = r_txd;
    assign gmii.gmii_tx_en = r_tx_en;
    assign gmii.gmii_tx_er = 1'b0;

`ifdef UDP_RX_CHECK_EN
    rx_state_t   r_rx_state, w_rx_state_nxt;
    logic        r_rx_dv_d, r_rx_err, r_rx_good, r_rx_bad;
    logic        w_rx_end, w_rx_ok, w_rx_crc_init, w_rx_crc_en;
    logic [31:0] w_rx_crc;

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        if (!gmii.gmii_rx_dv) begin
            w_rx_state_nxt = RX_IDLE;
        end else begin
            unique case (r_rx_state)
                RX_IDLE, RX_PREAMBLE: begin
                    if (gmii.gmii_rxd == SFD_BYTE)           w_rx_state_nxt = RX_DATA;
                    else if (gmii.gmii_rxd == PREAMBLE_BYTE) w_rx_state_nxt = RX_PREAMBLE;
                    else                                     w_rx_state_nxt = RX_DROP;
                end
                default: w_rx_state_nxt = r_rx_state;
            endcase
        end
    end

    // Only frames that reached the SFD are judged when rx_dv drops.
    assign w_rx_end      = r_rx_dv_d && !gmii.gmii_rx_dv && (r_rx_state == RX_DATA);
    assign w_rx_ok       = (w_rx_crc == CRC_RESIDUE) && !r_rx_err;
    assign w_rx_crc_init = (r_rx_state != RX_DATA);
    assign w_rx_crc_en   = (r_rx_state == RX_DATA) && gmii.gmii_rx_dv;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_dv_d  <= 1'b0;
            r_rx_err   <= 1'b0;
            r_rx_good  <= 1'b0;
            r_rx_bad   <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_dv_d  <= gmii.gmii_rx_dv;
            r_rx_good  <= w_rx_end && w_rx_ok;
            r_rx_bad   <= w_rx_end && !w_rx_ok;
            if (!gmii.gmii_rx_dv)     r_rx_err <= 1'b0;
            else if (gmii.gmii_rx_er) r_rx_err <= 1'b1;
        end
    end

    crc32_d8 u_rx_crc (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .i_init (w_rx_crc_init),
        .i_en   (w_rx_crc_en),
        .i_data (gmii.gmii_rxd),
        .o_crc  (w_rx_crc)
    );

    assign rx_good = r_rx_good;
    assign rx_bad  = r_rx_bad;
`else
    logic w_rx_unused;
    assign w_rx_unused = ^{gmii.gmii_rxd, gmii.gmii_rx_dv, gmii.gmii_rx_er};
    assign rx_good     = 1'b0;
    assign rx_bad      = 1'b0;
`endif

endmodule

// File: tb/tb_udp_test_top.sv
// Scoreboard bench for udp_test_top: GMII transmit looped back into receive, expected
// bytes and receive verdicts queued by a reference model and compared as the DUT emits them.
module tb_udp_test_top;

    localparam int          GAP       = 20;
    localparam int          PLEN      = 18;
    localparam int          FRAME_LEN = 8 + 42 + PLEN + 4;
    localparam int          FLIP_POS  = 8 + 42 + 5;
    localparam logic [47:0] M_DST     = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] M_SRC     = 48'h000A_3501_0203;
    localparam logic [31:0] M_SIP     = 32'hC0A8_010A;
    localparam logic [31:0] M_DIP     = 32'hC0A8_0102;
    localparam logic [15:0] M_PORT    = 16'd8080;

    logic clk = 1'b0;
    logic rst;
    logic link_up;
    logic led_link, rx_good, rx_bad;
    logic flip_en;
    logic [7:0] rx_flip;

    int n_vec = 0;
    int n_err = 0;
    int tx_pos = 0;
    int frames_done = 0;
    logic [7:0] cap [0:127];
    logic [7:0] exp_q[$];
    logic [1:0] rx_exp_q[$];

    always #4 clk = ~clk;

    udp_test_if u_if ();

    assign rx_flip        = (flip_en && tx_pos == FLIP_POS + 1) ? 8'h04 : 8'h00;
    assign u_if.gmii_rxd   = u_if.gmii_txd ^ rx_flip;
    assign u_if.gmii_rx_dv = u_if.gmii_tx_en;
    assign u_if.gmii_rx_er = 1'b0;

    udp_test_top #(.PAYLOAD_LEN(PLEN), .GAP_CYCLES(GAP)) dut (
        .sys_clk  (clk),
        .sys_rst  (rst),
        .link_up  (link_up),
        .gmii     (u_if),
        .led_link (led_link),
        .rx_good  (rx_good),
        .rx_bad   (rx_bad)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ d[b];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    // Reference frame: preamble, header, payload, FCS pushed to the byte scoreboard.
    task automatic push_frame(input logic [15:0] id);
        logic [15:0]  words [10];
        logic [31:0]  sum;
        logic [15:0]  csum;
        logic [335:0] h;
        logic [7:0]   body[$];
        logic [31:0]  c;
        logic [31:0]  fcs;
        words = '{16'h4500, 16'(28 + PLEN), id, 16'h4000, 16'h4011, 16'h0000,
                  M_SIP[31:16], M_SIP[15:0], M_DIP[31:16], M_DIP[15:0]};
        sum = 0;
        for (int i = 0; i < 10; i++) sum = sum + 32'(words[i]);
        while (sum[31:16] != 0) sum = 32'(sum[15:0]) + 32'(sum[31:16]);
        csum = ~sum[15:0];
        h = {M_DST, M_SRC, 16'h0800, 8'h45, 8'h00, 16'(28 + PLEN), id, 16'h4000, 8'h40, 8'h11,
             csum, M_SIP, M_DIP, M_PORT, M_PORT, 16'(8 + PLEN), 16'h0000};
        for (int i = 0; i < 42; i++) body.push_back(h[335 - 8*i -: 8]);
        for (int i = 0; i < PLEN; i++) body.push_back(8'(i));
        c = 32'hFFFF_FFFF;
        foreach (body[i]) c = crc_byte(c, body[i]);
        fcs = ~c;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (body[i]) exp_q.push_back(body[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
    endtask

    function automatic logic [63:0] cap_bytes(input int off, input int n);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = {v[55:0], cap[off + i]};
        return v;
    endfunction

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (frames_done < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("frame_wait", 64'(frames_done), 64'(n));
    endtask

    task automatic wait_tx_en(input int budget);
        int k;
        k = 0;
        while (!u_if.gmii_tx_en && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("tx_start_wait", 64'(u_if.gmii_tx_en), 64'd1);
    endtask

    // Monitor: byte scoreboard, idle-bus checks, frame length and receive verdicts.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            rx_exp_q.delete();
            tx_pos <= 0;
        end else begin
            if (rx_exp_q.size() > 0) check("rx_result", 64'({rx_good, rx_bad}), 64'(rx_exp_q.pop_front()));
            else                     check("rx_quiet", 64'({rx_good, rx_bad}), 64'd0);
            if (u_if.gmii_tx_en) begin
                if (exp_q.size() == 0) begin
                    check("tx_unexpected", 64'(u_if.gmii_tx_en), 64'd0);
                end else begin
                    check("tx_byte", 64'({u_if.gmii_tx_er, u_if.gmii_txd}), 64'({1'b0, exp_q.pop_front()}));
                end
                if (tx_pos < 128) cap[tx_pos] <= u_if.gmii_txd;
                tx_pos <= tx_pos + 1;
            end else begin
                check("tx_idle", 64'({u_if.gmii_tx_er, u_if.gmii_txd}), 64'd0);
                if (tx_pos > 0) begin
                    check("frame_len", 64'(tx_pos), 64'(FRAME_LEN));
`ifdef UDP_RX_CHECK_EN
                    rx_exp_q.push_back(flip_en ? 2'b01 : 2'b10);
`else
                    rx_exp_q.push_back(2'b00);
`endif
                    frames_done <= frames_done + 1;
                    tx_pos <= 0;
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        rst     = 1'b1;
        link_up = 1'b0;
        flip_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({led_link, rx_good, rx_bad, u_if.gmii_tx_en, u_if.gmii_tx_er, u_if.gmii_txd}), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Link up: LED latency and first-frame start latency.
        push_frame(16'd0);
        push_frame(16'd1);
        link_up = 1'b1;
        cnt = 0;
        while (!led_link && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("led_rise_lat", 64'(cnt), 64'd2);
        cnt = 0;
        while (!u_if.gmii_tx_en && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("first_txen_lat", 64'(cnt), 64'(GAP + 1));

        wait_frames(1, 200);
        check("preamble",     cap_bytes(0, 8),  64'h5555_5555_5555_55D5);
        check("dst_mac",      cap_bytes(8, 6),  64'hFFFF_FFFF_FFFF);
        check("src_mac",      cap_bytes(14, 6), 64'h000A_3501_0203);
        check("ethertype",    cap_bytes(20, 2), 64'h0800);
        check("ip_total_len", cap_bytes(24, 2), 64'h002E);
        check("ip_id_first",  cap_bytes(26, 2), 64'h0000);
        check("ip_csum",      cap_bytes(32, 2), 64'hB762);
        check("udp_len",      cap_bytes(46, 2), 64'h001A);

        wait_frames(2, 200);
        check("ip_id_second", cap_bytes(26, 2), 64'h0001);

        // Corrupt one payload bit on the receive path only.
        flip_en = 1'b1;
        push_frame(16'd2);
        wait_frames(3, 200);
        repeat (3) @(negedge clk);
        flip_en = 1'b0;

        // Link drop mid-frame: frame completes, LED follows, no further frames.
        push_frame(16'd3);
        wait_tx_en(200);
        repeat (10) @(negedge clk);
        link_up = 1'b0;
        cnt = 0;
        while (led_link && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("led_fall_lat", 64'(cnt), 64'd2);
        wait_frames(4, 200);
        repeat (4 * GAP + 20) @(negedge clk);
        check("no_frame_after_drop", 64'(frames_done), 64'd4);

        // Reset mid-frame: outputs clear next edge, sequence restarts at 0.
        link_up = 1'b1;
        push_frame(16'd4);
        wait_tx_en(200);
        repeat (15) @(negedge clk);
        check("pre_rst_txen", 64'(u_if.gmii_tx_en), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", 64'({led_link, rx_good, rx_bad, u_if.gmii_tx_en, u_if.gmii_tx_er, u_if.gmii_txd}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        push_frame(16'd0);
        wait_frames(5, 300);
        check("ip_id_after_rst", cap_bytes(26, 2), 64'h0000);
        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
